// File: rtl/key_sched.sv
// rtl/key_sched.sv - DES round-key generator with valid/ready handshake, encrypt or decrypt order
module key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        dec,
    input  logic [63:0] key,
    output logic [47:0] rk,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [3:0]  rk_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GEN,
        S_DONE
    } state_t;

    // Permuted choice 1: 1-based DES key bit positions, first 28 form C, next 28 form D.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: 1-based positions within the 56-bit C||D word.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1_fn(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_fn(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2[i]];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; every other round by two.
    function automatic logic shift_one(input logic [3:0] i);
        return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic [47:0] rk_q, rk_d;
    logic        rk_valid_q, rk_valid_d;
    logic [3:0]  rk_idx_q, rk_idx_d;
    logic [3:0]  idx_n;
    logic [3:0]  dec_sel;

    // Sequencing and key datapath: rotate C/D in place for the next index, then apply PC-2.
    // In decrypt order index j undoes shift SHIFT[16-j]; the wrap to index 0 on the last
    // accept undoes SHIFT[0], so C/D return to PC-1(key) in both directions.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        d_d        = d_q;
        dec_d      = dec_q;
        rk_d       = rk_q;
        rk_valid_d = rk_valid_q;
        rk_idx_d   = rk_idx_q;
        idx_n      = rk_idx_q + 4'd1;
        dec_sel    = 4'd0 - idx_n;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    {c_d, d_d} = pc1_fn(key);
                    dec_d      = dec;
                    rk_idx_d   = 4'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!dec_q) begin
                    c_d = rotl(c_q, shift_one(4'd0));
                    d_d = rotl(d_q, shift_one(4'd0));
                end
                rk_d       = pc2_fn({c_d, d_d});
                rk_valid_d = 1'b1;
                rk_idx_d   = 4'd0;
                state_d    = S_GEN;
            end
            S_GEN: begin
                if (rk_valid_q && rk_ready) begin
                    if (dec_q) begin
                        c_d = rotr(c_q, shift_one(dec_sel));
                        d_d = rotr(d_q, shift_one(dec_sel));
                    end else if (rk_idx_q != 4'd15) begin
                        c_d = rotl(c_q, shift_one(idx_n));
                        d_d = rotl(d_q, shift_one(idx_n));
                    end
                    if (rk_idx_q != 4'd15) begin
                        rk_d     = pc2_fn({c_d, d_d});
                        rk_idx_d = idx_n;
                    end else begin
                        rk_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            c_q        <= '0;
            d_q        <= '0;
            dec_q      <= 1'b0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            d_q        <= d_d;
            dec_q      <= dec_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
        end
    end

    assign rk       = rk_q;
    assign rk_valid = rk_valid_q;
    assign rk_idx   = rk_idx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_key_sched.sv
// tb/tb_key_sched.sv - self-checking bench for key_sched
module tb_key_sched;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        dec;
    logic [63:0] key;
    logic [47:0] rk;
    logic        rk_valid;
    logic        rk_ready;
    logic [3:0]  rk_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .dec      (dec),
        .key      (key),
        .rk       (rk),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reference: round r key is PC-2 of C0/D0 rotated left by the cumulative shift count.
    logic [47:0] model_k [16];

    task automatic compute_model(input logic [63:0] k);
        logic [55:0] cd0;
        int cum;
        int p;
        int src;
        for (int i = 0; i < 56; i++) cd0[55-i] = k[64-PC1[i]];
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
            for (int j = 0; j < 48; j++) begin
                p = PC2[j];
                if (p <= 28) src = ((p - 1 + cum) % 28) + 1;
                else         src = 28 + ((p - 29 + cum) % 28) + 1;
                model_k[r][47-j] = cd0[56-src];
            end
        end
    endtask

    // Monitor state
    bit          mon_en = 1'b0;
    int          exp_idx;
    logic [47:0] exp_keys [16];
    logic [47:0] acc_q [$];
    logic [47:0] last_rk;
    bit          stalled;
    int          valid_cycles, first_v, last_v, done_cnt, done_cyc;
    int          cyc = 0;

    // Compare process: checks DUT outputs mid-cycle against the expected sequence.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (rk_valid) begin
                check("busy_while_valid", busy, 1);
                if (exp_idx < 16) begin
                    check("rk_idx", rk_idx, exp_idx);
                    check("rk", rk, exp_keys[exp_idx]);
                end else begin
                    check("valid_past_end", rk_valid, 0);
                end
                if (stalled) check("rk_stable", rk, last_rk);
                last_rk = rk;
                if (valid_cycles == 0) first_v = cyc;
                last_v = cyc;
                valid_cycles++;
                if (rk_ready) begin
                    acc_q.push_back(rk);
                    exp_idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run(input logic [63:0] k, input logic d, input bit rnd, input bit inj7,
                       input bit rst9, input bit req_done, output bit aborted);
        bit injected;
        bit fin;
        compute_model(k);
        for (int i = 0; i < 16; i++) exp_keys[i] = d ? model_k[15-i] : model_k[i];
        exp_idx = 0;
        acc_q.delete();
        stalled = 1'b0;
        valid_cycles = 0;
        done_cnt = 0;
        done_cyc = -1;
        aborted = 1'b0;
        injected = 1'b0;
        fin = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; key = k; dec = d; rk_ready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; key = ~k; dec = ~d;
        check("load_busy", busy, 1);
        check("load_no_valid", rk_valid, 0);
        mon_en = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj7 && !injected && rk_valid && rk_idx == 4'd7) begin
                req = 1'b1; key = 64'h0123456789ABCDEF; dec = ~d; injected = 1'b1;
            end
            if (rst9 && rk_valid && rk_idx == 4'd9) begin
                mon_en = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("rst_rk", rk, 0);
                check("rst_rk_valid", rk_valid, 0);
                check("rst_rk_idx", rk_idx, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                aborted = 1'b1;
                fin = 1'b1;
            end else if (done) begin
                if (req_done) req = 1'b1;
                @(posedge clk); #1;
                req = 1'b0;
                check("done_one_cycle", done, 0);
                fin = 1'b1;
            end
        end
        mon_en = 1'b0;
        if (!aborted) begin
            check("finished_in_budget", fin, 1);
            check("done_count", done_cnt, 1);
            check("done_after_last_key", done_cyc, last_v + 1);
            check("idle_after_done", busy, 0);
            if (!rnd) begin
                check("valid_cycles", valid_cycles, 16);
                check("valid_contiguous", last_v - first_v + 1, 16);
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("stays_idle", busy, 0);
            check("no_restart_valid", rk_valid, 0);
            check("accepted_count", acc_q.size(), 16);
            for (int i = 0; i < 16 && i < acc_q.size(); i++) check("seq", acc_q[i], exp_keys[i]);
        end
    endtask

    bit ab;

    initial begin
        rst_n = 1'b0; req = 1'b0; dec = 1'b0; key = '0; rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rk", rk, 0);
        check("reset_rk_valid", rk_valid, 0);
        check("reset_rk_idx", rk_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;

        compute_model(KEY_A);
        check("model_k1", model_k[0], 48'h1B02EFFC7072);
        check("model_k2", model_k[1], 48'h79AED9DBC9E5);
        check("model_k16", model_k[15], 48'hCB3D8B0E17F5);

        run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ab);
        if (acc_q.size() == 16) begin
            check("enc_idx0", acc_q[0], 48'h1B02EFFC7072);
            check("enc_idx15", acc_q[15], 48'hCB3D8B0E17F5);
        end

        run(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ab);
        if (acc_q.size() == 16) begin
            check("dec_idx0", acc_q[0], 48'hCB3D8B0E17F5);
            check("dec_idx15", acc_q[15], 48'h1B02EFFC7072);
        end

        run(KEY_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ab);
        run(KEY_A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ab);
        run(KEY_A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ab);

        run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ab);
        check("reset_taken", ab, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_resume_busy", busy, 0);
        check("no_resume_valid", rk_valid, 0);
        run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ab);

        run(64'h0000000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ab);
        for (int i = 0; i < acc_q.size(); i++) check("zero_key", acc_q[i], 48'h000000000000);
        run(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ab);
        for (int i = 0; i < acc_q.size(); i++) check("ones_key", acc_q[i], 48'hFFFFFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_sched.md
KEY_SCHED -- requirements
Module: key_sched

Interface
REQ-001 The block SHALL have an input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have an input rst_n, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have an input req, 1 bit: start key expansion; sampled only in IDLE.
REQ-004 The block SHALL have an input dec, 1 bit: 0 selects encryption order K1..K16, 1 selects decryption order K16..K1; captured with req.
REQ-005 The block SHALL have an input key, 64 bits: DES key, bit 1 = key[63]; parity bits 8,16,...,64 ignored; captured with req.
REQ-006 The block SHALL have an output rk, 48 bits: current round key, PC-2 bit 1 = rk[47].
REQ-007 The block SHALL have an output rk_valid, 1 bit: rk holds a valid round key.
REQ-008 The block SHALL have an input rk_ready, 1 bit: the downstream round sequencer accepts rk this cycle.
REQ-009 The block SHALL have an output rk_idx, 4 bits: sequence index 0..15 of the key on rk (not the DES round number).
REQ-010 The block SHALL have an output busy, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have an output done, 1 bit: one-cycle pulse after the 16th key is accepted.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, GEN, DONE.
REQ-013 IDLE with req=1 SHALL capture PC-1(key) into 28-bit registers C and D, latch dec, clear the index, and move to LOAD.
REQ-014 LOAD SHALL, on the next edge, register rk, set rk_valid=1 and rk_idx=0, and move to GEN; rk_valid therefore rises on the second edge after req is sampled.
REQ-015 In encryption, the key for index i SHALL be PC-2 of C,D after each of C and D is rotated left by SHIFT[i].
REQ-016 SHIFT[i] SHALL be 1 for i in {0,1,8,15} and 2 otherwise; the rotated C,D SHALL be written back.
REQ-017 In decryption, index 0 SHALL be PC-2 of the unrotated C,D.
REQ-018 In decryption, index j>0 SHALL first rotate C and D right by SHIFT[16-j] and write them back.
REQ-019 In GEN, while rk_valid=1 and rk_ready=0, rk, rk_idx, C and D SHALL hold stable.
REQ-020 In GEN, rk_valid=1 and rk_ready=1 with rk_idx<15 SHALL present the next key on the following edge, with no bubble and rk_valid remaining 1.
REQ-021 In GEN, rk_valid=1 and rk_ready=1 with rk_idx=15 SHALL clear rk_valid and move to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 req SHALL be ignored in LOAD, GEN and DONE; it SHALL NOT restart or corrupt an expansion in progress.
REQ-024 req asserted in the cycle done=1 SHALL be ignored; it is honoured only once the FSM is back in IDLE.
REQ-025 rk_ready SHALL be ignored whenever rk_valid=0.
REQ-026 The accepted key sequence SHALL be independent of stall pattern: any rk_ready gaps give the same 16 keys in the same order.
REQ-027 After DONE, C and D SHALL equal PC-1(key): the total rotation is 28 in both directions.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and in any state including mid-GEN, force IDLE and set rk=0, rk_valid=0, rk_idx=0, busy=0, done=0, C=0, D=0, dec=0.
REQ-029 On release of reset, the block SHALL wait in IDLE for req; no partial sequence SHALL resume.

Verification
REQ-030 The bench SHALL cover: key=0x133457799BBCDFF1, dec=0, rk_ready=1 always -> idx0 rk=0x1B02EFFC7072, idx15 rk=0xCB3D8B0E17F5, 16 consecutive valid cycles, then done pulse.
REQ-031 The bench SHALL cover: same key, dec=1 -> idx0 rk=0xCB3D8B0E17F5, idx15 rk=0x1B02EFFC7072.
REQ-032 The bench SHALL cover: same key, dec=0, rk_ready toggled pseudo-randomly -> the accepted sequence is identical to the REQ-030 sequence; rk is stable during every stall.
REQ-033 The bench SHALL cover: req pulsed with a different key while at idx7 -> sequence unaffected; busy stays 1.
REQ-034 The bench SHALL cover: rst_n low at idx9 -> all outputs 0 immediately without a clock edge; a new req afterwards yields a full fresh sequence from idx0.
REQ-035 The bench SHALL cover: key=0x0000000000000000 and key=0xFFFFFFFFFFFFFFFF -> all 16 rk are 0x000000000000 and 0xFFFFFFFFFFFF respectively.
